// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared FSM state type and sizing constants for seq_detect_param
package seq_detect_pkg;
  typedef enum logic {FILL, HUNT} state_t;
  localparam int LEN_MIN   = 2;
  localparam int LEN_MAX   = 16;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/seq_match_cnt.sv
// seq_match_cnt: saturating event counter with synchronous clear that beats increment
module seq_match_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  // clear wins over increment; increment stops once all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with loadable pattern; macro SEQ_DETECT_CNT_EN enables the match counter
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(4'b1001),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inp,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(LEN + 1);
  if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_len_check
    $error("seq_detect_param: LEN=%0d outside %0d..%0d", LEN, LEN_MIN, LEN_MAX);
  end
  state_t         r_state, w_state_nxt;
  logic [LEN-1:0] r_pat, r_hist, w_pat_nxt, w_hist_nxt, w_hist_sh;
  logic [FW-1:0]  r_fill, w_fill_nxt, w_fill_inc;
  logic           r_match, w_hit;
  // next state: load beats sampling; a non-overlapping hit restarts the fill
  always_comb begin
    w_hist_sh   = {r_hist[LEN-2:0], inp};
    w_fill_inc  = (r_state == FILL) ? r_fill + FW'(1) : r_fill;
    w_hit       = in_valid && !cfg_load && (w_hist_sh == r_pat) && (w_fill_inc == FW'(LEN));
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    if (cfg_load) begin
      w_pat_nxt   = cfg_pattern;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = FILL;
    end else if (in_valid) begin
      w_hist_nxt  = w_hist_sh;
      w_fill_nxt  = (w_hit && !OVERLAP) ? '0 : w_fill_inc;
      w_state_nxt = (w_hit && !OVERLAP) ? FILL : ((w_fill_inc == FW'(LEN)) ? HUNT : FILL);
    end
  end
  // state register; reset restores the build-time pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_hit;
    end
  end
  assign match = r_match;
`ifdef SEQ_DETECT_CNT_EN
  seq_match_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_hit),
    .i_clr (cnt_clr),
    .o_cnt (match_cnt)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign match_cnt    = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench driving three detector variants with shared directed stimulus
module tb_seq_detect_param;
  logic       clk = 1'b0, rst_n = 1'b0, inp = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int checks = 0, errors = 0, vec = 0;
  typedef struct {int idx; logic [2:0] m; int c0; int c1; int c2;} exp_t;
  exp_t q[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  seq_detect_param d0 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr), .match(m0), .match_cnt(c0));
  seq_detect_param #(.OVERLAP(1'b0)) d1 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr), .match(m1), .match_cnt(c1));
  seq_detect_param #(.CNT_W(2)) d2 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr), .match(m2), .match_cnt(c2));

  function automatic int cnt_exp(int c);
`ifdef SEQ_DETECT_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic check_zero(int idx);
    chk("rst_match0", idx, int'(m0), 0);
    chk("rst_match1", idx, int'(m1), 0);
    chk("rst_match2", idx, int'(m2), 0);
    chk("rst_cnt0", idx, int'(c0), 0);
    chk("rst_cnt1", idx, int'(c1), 0);
    chk("rst_cnt2", idx, int'(c2), 0);
  endtask

  task automatic step(logic i, logic v, logic l, logic [3:0] p, logic c,
                      logic e_m0, logic e_m1, logic e_m2, int e0, int e1, int e2);
    inp = i; in_valid = v; cfg_load = l; cfg_pattern = p; cnt_clr = c;
    @(posedge clk);
    q.push_back('{vec, {e_m2, e_m1, e_m0}, cnt_exp(e0), cnt_exp(e1), cnt_exp(e2)});
    vec++;
    #1;
  endtask

  task automatic s(logic i, logic e_m0, logic e_m1, logic e_m2, int e0, int e1, int e2);
    step(i, 1'b1, 1'b0, 4'b0000, 1'b0, e_m0, e_m1, e_m2, e0, e1, e2);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero(vec);
    #1 rst_n = 1'b1;
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("match0", e_mon.idx, int'(m0), int'(e_mon.m[0]));
      chk("match1", e_mon.idx, int'(m1), int'(e_mon.m[1]));
      chk("match2", e_mon.idx, int'(m2), int'(e_mon.m[2]));
      chk("cnt0", e_mon.idx, int'(c0), e_mon.c0);
      chk("cnt1", e_mon.idx, int'(c1), e_mon.c1);
      chk("cnt2", e_mon.idx, int'(c2), e_mon.c2);
    end
  end

  initial begin
    #2 check_zero(-1);
    @(negedge clk);
    rst_n = 1'b1;
    s(1,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(1,1,1,1,1,1,1);
    s(0,0,0,0,1,1,1); s(0,0,0,0,1,1,1); s(1,1,0,1,2,1,2);
    rst_pulse();
    s(1,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(0,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 4'b0000, 0, 0,0,0, 0,0,0);
    s(1,1,1,1,1,1,1);
    s(1,0,0,0,1,1,1); s(0,0,0,0,1,1,1); s(0,0,0,0,1,1,1);
    rst_pulse();
    s(1,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(1,1,1,1,1,1,1);
    s(1,0,0,0,1,1,1); s(1,0,0,0,1,1,1);
    step(1, 1, 1, 4'b1101, 0, 0,0,0, 1,1,1);
    s(1,0,0,0,1,1,1); s(1,0,0,0,1,1,1); s(0,0,0,0,1,1,1); s(1,1,1,1,2,2,2);
    s(1,0,0,0,2,2,2); s(0,0,0,0,2,2,2); s(0,0,0,0,2,2,2); s(1,0,0,0,2,2,2);
    rst_pulse();
    s(1,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(0,0,0,0,0,0,0); s(1,1,1,1,1,1,1);
    s(0,0,0,0,1,1,1); s(0,0,0,0,1,1,1); s(1,1,0,1,2,1,2);
    s(0,0,0,0,2,1,2); s(0,0,0,0,2,1,2); s(1,1,1,1,3,2,3);
    s(0,0,0,0,3,2,3); s(0,0,0,0,3,2,3); s(1,1,0,1,4,2,3);
    s(0,0,0,0,4,2,3); s(0,0,0,0,4,2,3); s(1,1,1,1,5,3,3);
    s(0,0,0,0,5,3,3); s(0,0,0,0,5,3,3);
    step(1, 1, 0, 4'b0000, 1, 1,0,1, 0,0,0);
    s(0,0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    #1 chk("drain", vec, q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameters SHALL be:
- LEN, default 4, pattern length in bits, legal 2..16.
- PATTERN, default 4'b1001, reset-time pattern, LEN bits wide, MSB is the first bit received.
- OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
- CNT_W, default 8, match counter width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inp  in  1  serial data bit.
- in_valid  in  1  inp is sampled only when high.
- cfg_load  in  1  load a new pattern.
- cfg_pattern  in  LEN  new pattern value.
- cnt_clr  in  1  clear the match counter.
- match  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating match count.
REQ-003 The block SHALL use one clock (clk) with asynchronous, active-low reset (rst_n); no other clock or reset SHALL exist.

Function
REQ-004 Internal state SHALL consist of:
- pattern register pat_q (LEN bits);
- history shift register hist_q (LEN bits); each sampled bit shifts in at the LSB;
- fill counter fill_q (0..LEN).
REQ-005 The FSM SHALL have two states:
- FILL: fill_q < LEN. Each sampled bit increments fill_q. The FSM moves to HUNT when fill_q reaches LEN.
- HUNT: comparison is active.
REQ-006 A sample SHALL occur on a rising clk edge with in_valid=1 and cfg_load=0. With in_valid=0, all state SHALL hold and match SHALL be 0 on that edge.
REQ-007 A match SHALL be detected when the post-shift history {hist_q[LEN-2:0], inp} equals pat_q and the post-sample fill count equals LEN.
REQ-008 match SHALL be 1 exactly on the edge that samples the final pattern bit, for one cycle. It SHALL be 0 on every other edge (zero-latency registered Mealy).
REQ-009 With OVERLAP=1, history and fill count SHALL be kept after a match, so "1001001" yields 2 matches.
REQ-010 With OVERLAP=0, a match SHALL clear fill_q to 0 and return the FSM to FILL, so "1001001" yields 1 match.
REQ-011 cfg_load=1 on an edge SHALL:
- load pat_q from cfg_pattern;
- clear hist_q and fill_q and return to FILL;
- force match=0;
- discard any inp sampled on that edge. cfg_load has priority over in_valid.
REQ-012 match_cnt SHALL increment by 1 per match. It SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-013 If cnt_clr and a match occur on the same edge, cnt_clr SHALL win and match_cnt SHALL become 0. cfg_load SHALL NOT affect match_cnt.

Reset
REQ-014 When rst_n=0, the block SHALL immediately, without waiting for clk, set:
- match=0, match_cnt=0, hist_q=0, fill_q=0, FSM=FILL;
- pat_q=PATTERN.
REQ-015 Reset asserted mid-sequence SHALL discard partial progress: a pattern straddling the reset SHALL NOT match.
REQ-016 Reset deassertion SHALL be treated as asynchronous to clk; the first sample is taken on the first rising edge after rst_n=1.

Configuration
REQ-017 The macro SEQ_DETECT_CNT_EN SHALL control the match counter:
- Defined: match_cnt and cnt_clr are functional per REQ-012/013.
- Not defined: match_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL be synthesised. Port list is unchanged.

Structure
REQ-018 A shared package seq_detect_pkg SHALL hold:
- the FSM state typedef (FILL, HUNT);
- the LEN legal-range constants (2, 16);
- the default CNT_W.
REQ-019 One sub-module, seq_match_cnt (saturating counter with clear), SHALL be instantiated only under SEQ_DETECT_CNT_EN. All other logic SHALL be in seq_detect_param.
REQ-020 An illegal LEN SHALL produce an elaboration-time error.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Defaults, OVERLAP=1, in_valid=1, bits 1,0,0,1,0,0,1 -> match high on the 4th and 7th sample edges; match_cnt=2.
- OVERLAP=0, same bits -> match only on the 4th edge; match_cnt=1.
- Bits 1,0,0 then in_valid=0 for 3 cycles, then bit 1 -> match on the edge sampling the final 1; match=0 during the gap.
- cfg_load with cfg_pattern=4'b1101 after 2 sampled bits, then 1,1,0,1 -> match on the 4th post-load edge; 1,0,0,1 afterwards -> no match.
- rst_n pulsed low after bits 1,0,0, then bit 1 -> no match; all outputs 0 while rst_n=0, with no clk edge needed.
- CNT_W=2 with 5 matches -> match_cnt saturates at 3; cnt_clr coincident with a match -> 0; macro undefined -> match_cnt stays 0 throughout.
